// File: rtl/discrete_gated_vco_voice.sv
// Discrete-style gated VCO voice: slew-limited envelope FSM, square LFO and
// filtered control voltage drive a square VCO that gates the envelope, then
// a one-pole HP, one-pole LP and asymmetric gain stage produce the sample.
// Every register advances only on audio_clk_en; each stage consumes the
// previous-sample value of its inputs.
module discrete_gated_vco_voice #(
  parameter int CLOCK_RATE      = 1000000,
  parameter int SAMPLE_RATE     = 48000,
  parameter int TRIG_ACTIVE_LOW = 1,
  parameter int ONE_SHOT        = 0,
  parameter int ENV_MAX         = 6826,
  parameter int SLEW_STEP       = 20,
  parameter int HOLD_SAMPLES    = 100,
  parameter int LFO_HALF_PERIOD = 1200,
  parameter int LFO_AMP         = 2000,
  parameter int CTRL_LP_SHIFT   = 4,
  parameter int VCO_BASE_INC    = 400,
  parameter int VCO_DEPTH       = 16,
  parameter int HP_SHIFT        = 6,
  parameter int LP_SHIFT        = 2,
  parameter int POS_GAIN        = 6,
  parameter int NEG_GAIN        = 3
) (
  input  logic               clk,
  input  logic               I_RSTn,
  input  logic               audio_clk_en,
  input  logic               trigger,
  output logic signed [15:0] out,
  output logic               busy
);

  // The sample strobe cannot run faster than the clock it is derived from.
  if (SAMPLE_RATE <= 0 || SAMPLE_RATE > CLOCK_RATE) begin : g_bad_rate
    $error("SAMPLE_RATE must be in 1..CLOCK_RATE");
  end

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ATTACK  = 2'd1;
  localparam logic [1:0] S_SUSTAIN = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  localparam logic        OS        = (ONE_SHOT != 0);
  localparam logic        TAL       = (TRIG_ACTIVE_LOW != 0);
  localparam logic [15:0] ENV_MAX_W = 16'(ENV_MAX);
  localparam logic [16:0] STEP_W    = 17'(SLEW_STEP);
  localparam logic [15:0] HOLD_W    = 16'(HOLD_SAMPLES);
  localparam logic [15:0] LFO_LAST  = 16'(LFO_HALF_PERIOD - 1);
  localparam logic signed [17:0] LFO_POS = 18'(LFO_AMP);
  localparam logic signed [17:0] LFO_NEG = 18'(-LFO_AMP);
  localparam logic signed [23:0] G_POS   = 24'(POS_GAIN);
  localparam logic signed [23:0] G_NEG   = 24'(NEG_GAIN);

  logic [1:0]  state, state_n;
  logic [15:0] env, env_n, env_up, env_dn;
  logic [15:0] hold_cnt, hold_n;
  logic [16:0] up_sum;
  logic        trig, trig_q, rise, start;

  logic [15:0]        lfo_cnt, phase, inc;
  logic               lfo_neg;
  logic signed [17:0] lfo, env_s, ctrl, ctrl_f;
  logic signed [18:0] ctrl_d;
  logic signed [31:0] inc_raw;

  logic signed [17:0] g, hp_lp, hp, lp;
  logic signed [18:0] hp_d, lp_d;
  logic signed [23:0] prod, scaled;
  logic signed [15:0] out_n;

  assign trig  = trigger ^ TAL;
  assign rise  = trig & ~trig_q;
  assign start = OS ? rise : trig;
  assign busy  = (state != S_IDLE);

  assign up_sum = {1'b0, env} + STEP_W;
  assign env_up = (up_sum >= {1'b0, ENV_MAX_W}) ? ENV_MAX_W : up_sum[15:0];
  assign env_dn = ({1'b0, env} > STEP_W) ? (env - STEP_W[15:0]) : 16'd0;

  // Envelope FSM next-state; a state entered this sample applies its own step
  // immediately, except the one-shot hold exit which only changes state.
  always_comb begin
    state_n = state;
    env_n   = env;
    hold_n  = hold_cnt;
    case (state)
      S_IDLE: begin
        env_n = '0;
        if (start) begin
          state_n = S_ATTACK;
          env_n   = env_up;
        end
      end
      S_ATTACK: begin
        if (!OS && !trig) begin
          state_n = S_RELEASE;
          env_n   = env_dn;
        end else begin
          env_n = env_up;
        end
      end
      S_SUSTAIN: begin
        if (OS) begin
          if (hold_cnt >= HOLD_W) state_n = S_RELEASE;
          else                    hold_n  = hold_cnt + 16'd1;
        end else if (!trig) begin
          state_n = S_RELEASE;
          env_n   = env_dn;
        end
      end
      S_RELEASE: begin
        if (start) begin
          state_n = S_ATTACK;
          env_n   = env_up;
        end else begin
          env_n = env_dn;
        end
      end
      default: begin
        state_n = S_IDLE;
        env_n   = '0;
      end
    endcase
    // Landing on a rail finishes the ramp in the same sample.
    if (state_n == S_ATTACK && env_n == ENV_MAX_W) begin
      state_n = S_SUSTAIN;
      hold_n  = '0;
    end
    if (state_n == S_RELEASE && env_n == 16'd0) state_n = S_IDLE;
  end

  // Envelope state, hold counter and trigger history.
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state    <= S_IDLE;
      env      <= '0;
      hold_cnt <= '0;
      trig_q   <= 1'b0;
    end else if (audio_clk_en) begin
      state    <= state_n;
      env      <= env_n;
      hold_cnt <= hold_n;
      trig_q   <= trig;
    end
  end

  assign lfo     = lfo_neg ? LFO_NEG : LFO_POS;
  assign env_s   = signed'({2'b00, env});
  assign ctrl    = (env_s >>> 1) + lfo;
  assign ctrl_d  = ctrl - ctrl_f;
  assign inc_raw = 32'(VCO_BASE_INC) + ((32'(ctrl_f) * 32'(VCO_DEPTH)) >>> 8);
  assign inc     = (inc_raw < 32'sd1)     ? 16'd1 :
                   (inc_raw > 32'sd32767) ? 16'd32767 : inc_raw[15:0];

  // Free-running LFO, control low-pass and VCO phase accumulator.
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      lfo_cnt <= '0;
      lfo_neg <= 1'b0;
      ctrl_f  <= '0;
      phase   <= '0;
    end else if (audio_clk_en) begin
      if (lfo_cnt >= LFO_LAST) begin
        lfo_cnt <= '0;
        lfo_neg <= ~lfo_neg;
      end else begin
        lfo_cnt <= lfo_cnt + 16'd1;
      end
      ctrl_f <= ctrl_f + 18'(ctrl_d >>> CTRL_LP_SHIFT);
      phase  <= phase + inc;
    end
  end

  assign hp_d = g - hp_lp;
  assign lp_d = hp - lp;

  // Asymmetric gain with saturation to the 16-bit output range.
  always_comb begin
    prod   = (lp > 18'sd0) ? (24'(lp) * G_POS) : (24'(lp) * G_NEG);
    scaled = prod >>> 2;
    if (scaled > 24'sd32767)       out_n = 16'sh7fff;
    else if (scaled < -24'sd32768) out_n = 16'sh8000;
    else                           out_n = scaled[15:0];
  end

  // Audio chain: gate -> high-pass -> low-pass -> output, one sample per stage.
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      g     <= '0;
      hp_lp <= '0;
      hp    <= '0;
      lp    <= '0;
      out   <= '0;
    end else if (audio_clk_en) begin
      g     <= phase[15] ? env_s : 18'sd0;
      hp_lp <= hp_lp + 18'(hp_d >>> HP_SHIFT);
      hp    <= 18'(hp_d);
      lp    <= lp + 18'(lp_d >>> LP_SHIFT);
      out   <= out_n;
    end
  end

endmodule

// File: tb/tb_discrete_gated_vco_voice.sv
// Scoreboard bench for discrete_gated_vco_voice. Four instances share clock,
// strobe and reset: gate-mode default (g), one-shot (o), HP-bypassed
// asymmetry probe (a) and a never-triggered idle voice (i).
module tb_discrete_gated_vco_voice;

  logic clk, I_RSTn, en, hold_en;
  logic trig_g, trig_o, trig_a, trig_i;
  logic signed [15:0] out_g, out_o, out_a, out_i;
  logic busy_g, busy_o, busy_a, busy_i;

  discrete_gated_vco_voice dut_g (.clk(clk), .I_RSTn(I_RSTn), .audio_clk_en(en),
    .trigger(trig_g), .out(out_g), .busy(busy_g));
  discrete_gated_vco_voice #(.ONE_SHOT(1)) dut_o (.clk(clk), .I_RSTn(I_RSTn),
    .audio_clk_en(en), .trigger(trig_o), .out(out_o), .busy(busy_o));
  discrete_gated_vco_voice #(.HP_SHIFT(15), .LP_SHIFT(0)) dut_a (.clk(clk),
    .I_RSTn(I_RSTn), .audio_clk_en(en), .trigger(trig_a), .out(out_a), .busy(busy_a));
  discrete_gated_vco_voice dut_i (.clk(clk), .I_RSTn(I_RSTn), .audio_clk_en(en),
    .trigger(trig_i), .out(out_i), .busy(busy_i));

  typedef struct {int at; int sel; int exp; string name;} exp_t;
  exp_t sb[$];

  localparam int ENV_G = 0, BUSY_G = 1, ENV_O = 2, BUSY_O = 3, BCNT_O = 4,
                 MAX_A = 5, MIN_A = 6, ACT_G = 7, NZ_I = 8;

  int checks = 0, errors = 0, smp = 0;
  bit mon_on = 0;
  int chg_g = 0, nz_g = 0, bcnt_o = 0, nz_i = 0;
  int max_a = -100000, min_a = 100000;
  logic signed [15:0] last_out_g = '0;

  initial clk = 0;
  always #5 clk = ~clk;

  // Strobe every other clock unless held off.
  initial begin
    en = 0;
    forever begin
      @(negedge clk);
      if (hold_en) en = 0;
      else         en = ~en;
    end
  end

  function automatic int actual(int sel);
    case (sel)
      ENV_G:   return int'(dut_g.env);
      BUSY_G:  return int'(busy_g);
      ENV_O:   return int'(dut_o.env);
      BUSY_O:  return int'(busy_o);
      BCNT_O:  return bcnt_o;
      MAX_A:   return max_a;
      MIN_A:   return min_a;
      ACT_G:   return (chg_g > 0 && nz_g > 0) ? 1 : 0;
      NZ_I:    return nz_i;
      default: return -1;
    endcase
  endfunction

  task automatic push(int at, int sel, int exp, string nm);
    exp_t e;
    e.at = at; e.sel = sel; e.exp = exp; e.name = nm;
    sb.push_back(e);
  endtask

  // Monitor: on strobe edges pop due expectations; on idle edges nothing may move.
  initial begin
    logic [67:0] prev, cur;
    logic en_s;
    int act;
    prev = '0;
    forever begin
      @(posedge clk);
      en_s = en;
      #1;
      cur = {out_g, out_o, out_a, out_i, busy_g, busy_o, busy_a, busy_i};
      if (mon_on) begin
        if (en_s) begin
          smp++;
          if (smp >= 360 && smp <= 510) begin
            if (out_g != last_out_g) chg_g++;
            if (out_g != 0) nz_g++;
          end
          last_out_g = out_g;
          if (smp >= 400 && smp <= 2000) begin
            if (int'(out_a) > max_a) max_a = int'(out_a);
            if (int'(out_a) < min_a) min_a = int'(out_a);
          end
          if (smp <= 1000 && busy_o) bcnt_o++;
          if (smp <= 5000 && (out_i != 0 || busy_i)) nz_i++;
          for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == smp) begin
              act = actual(sb[i].sel);
              checks++;
              if (act != sb[i].exp) begin
                errors++;
                $display("FAIL %s @sample %0d: got %0d, want %0d", sb[i].name, smp, act, sb[i].exp);
              end
              sb.delete(i);
            end
          end
        end else begin
          checks++;
          if (cur != prev) begin
            errors++;
            $display("FAIL hold_no_strobe @sample %0d: got %h, want %h", smp, cur, prev);
          end
        end
      end
      prev = cur;
    end
  end

  task automatic wait_smp(int n);
    int guard = 0;
    while (smp < n && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (smp != n) begin
      checks++; errors++;
      $display("FAIL wait_sample: got %0d, want %0d", smp, n);
    end
  endtask

  initial begin
    hold_en = 0;
    I_RSTn = 0;
    trig_g = 1; trig_o = 1; trig_a = 1; trig_i = 1;

    // Reset held: triggers wiggle, outputs must stay silent.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      trig_g = k[0]; trig_o = ~k[0]; trig_a = k[0];
      #2;
      checks++;
      if ({out_g, out_o, out_a, out_i, busy_g, busy_o, busy_a, busy_i} != '0) begin
        errors++;
        $display("FAIL reset_quiet cycle %0d: got %h, want 0", k,
                 {out_g, out_o, out_a, out_i, busy_g, busy_o, busy_a, busy_i});
      end
    end

    // Gate voice: attack from 10, release at 510, retrigger tests from 900.
    push(10, BUSY_G, 0, "g_busy_pre");
    push(11, ENV_G, 20, "g_env_first");
    push(11, BUSY_G, 1, "g_busy_rise");
    push(12, ENV_G, 40, "g_env_second");
    push(351, ENV_G, 6820, "g_env_341");
    push(352, ENV_G, 6826, "g_env_full");
    push(500, ENV_G, 6826, "g_sustain");
    push(511, ENV_G, 6806, "g_rel_first");
    push(511, ACT_G, 1, "g_out_active");
    push(851, ENV_G, 6, "g_rel_last");
    push(851, BUSY_G, 1, "g_busy_tail");
    push(852, ENV_G, 0, "g_env_zero");
    push(852, BUSY_G, 0, "g_busy_fall");
    push(1242, ENV_G, 6826, "g_reattack_full");
    push(1350, ENV_G, 4826, "g_rel_100");
    push(1350, BUSY_G, 1, "g_busy_rel");
    push(1351, ENV_G, 4846, "g_retrig_step");
    push(1449, ENV_G, 6806, "g_retrig_99");
    push(1450, ENV_G, 6826, "g_retrig_full");
    // One-shot voice: pulse at 20, ignored pulse at 400, pulse again at 5010.
    push(20, BUSY_O, 0, "o_busy_pre");
    push(21, ENV_O, 20, "o_env_first");
    push(21, BUSY_O, 1, "o_busy_rise");
    push(362, ENV_O, 6826, "o_env_full");
    push(463, ENV_O, 6826, "o_hold_end");
    push(464, ENV_O, 6806, "o_rel_first");
    push(804, ENV_O, 6, "o_rel_last");
    push(804, BUSY_O, 1, "o_busy_tail");
    push(805, ENV_O, 0, "o_env_zero");
    push(805, BUSY_O, 0, "o_busy_fall");
    push(1000, BCNT_O, 784, "o_busy_len");
    push(5020, ENV_O, 200, "o_env_pre_reset");
    // Asymmetry probe and idle silence.
    push(2001, MAX_A, 10239, "a_peak");
    push(2001, MIN_A, 0, "a_floor");
    push(5000, NZ_I, 0, "i_silence");

    @(negedge clk);
    trig_g = 1; trig_o = 1; trig_a = 1; trig_i = 1;
    I_RSTn = 1;
    mon_on = 1;

    wait_smp(10);   trig_g = 0;
    wait_smp(20);   trig_o = 0;
    wait_smp(21);   trig_o = 1;
    wait_smp(30);   trig_a = 0;
    wait_smp(400);  trig_o = 0;
    wait_smp(401);  trig_o = 1;
    wait_smp(510);  trig_g = 1;
    wait_smp(900);  trig_g = 0;
    wait_smp(1250); trig_g = 1;
    wait_smp(1350); trig_g = 0;
    wait_smp(2100); hold_en = 1;
    repeat (40) @(negedge clk);
    hold_en = 0;
    wait_smp(5010); trig_o = 0;
    wait_smp(5011); trig_o = 1;
    wait_smp(5020);
    mon_on = 0;

    foreach (sb[i]) begin
      checks++; errors++;
      $display("FAIL %s never reached: at %0d, now %0d", sb[i].name, sb[i].at, smp);
    end

    // Asynchronous reset in the middle of a one-shot attack.
    #2;
    I_RSTn = 0;
    #1;
    checks++;
    if (dut_o.env != 16'd0) begin
      errors++;
      $display("FAIL async_reset_env: got %0d, want 0", dut_o.env);
    end
    checks++;
    if ({busy_g, busy_o, busy_a, busy_i} != 4'b0) begin
      errors++;
      $display("FAIL async_reset_busy: got %b, want 0000", {busy_g, busy_o, busy_a, busy_i});
    end
    checks++;
    if ({out_g, out_o, out_a, out_i} != '0) begin
      errors++;
      $display("FAIL async_reset_out: got %h, want 0", {out_g, out_o, out_a, out_i});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
